rs485_telemetry_tx: RTL and testbench

Half-duplex RS485 telemetry transmitter that drives RS485D/RS485DE from the 160 MHz system clock. When the QCW driver finishes a burst, it latches the burst results (peak current from the over-current detector, cycle count, fault/halt flags) and serializes them as a fixed 6-byte UART frame (8N1, LSB first). It controls the driver-enable line, including lead and tail guard times. It is the transmitting end of the telemetry link; the remote station's receiver decodes the frame.

---
 rtl/rs485_telemetry_tx.sv | 172 +++++++++++++++++
 tb/tb_rs485_telemetry_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_telemetry_tx.sv
// RS485 telemetry transmitter: latches burst results on send and shifts out a
// 6-byte 8N1 frame, framed by driver-enable lead and tail guard intervals.
module rs485_telemetry_tx #(
  parameter int CLK_DIV = 160,
  parameter int DE_LEAD = 32,
  parameter int DE_TAIL = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [9:0] current_max,
  input  logic [15:0] cycle_count,
  input  logic       fault,
  input  logic       halt,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       overrun
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LEAD_M1 = 16'(DE_LEAD - 1);
  localparam logic [15:0] TAIL_M1 = 16'(DE_TAIL - 1);
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_START, S_DATA, S_STOP, S_TAIL
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_reg;
  logic [2:0]  byte_reg;
  logic [7:0]  shift_reg;
  logic        line_reg;
  logic [7:0]  b1_reg, b2_reg, b3_reg, b4_reg, b5_reg;
  logic        tx_reg, tx_en_reg, busy_reg, overrun_reg;

  logic [7:0] cap_b1;
  logic [7:0] cap_sum;
  logic [7:0] cur_byte;
  logic       accept;

  assign cap_b1  = {fault, halt, 4'b0000, current_max[9:8]};
  assign cap_sum = cap_b1 + current_max[7:0] + cycle_count[15:8] + cycle_count[7:0];

  // busy_reg still high on the cycle after the FSM reaches IDLE, so a send
  // there counts as overlapping the previous frame.
  assign accept = send && (state_reg == S_IDLE) && !busy_reg;

  always_comb begin
    cur_byte = b5_reg;
    case (byte_reg)
      3'd0:    cur_byte = SYNC;
      3'd1:    cur_byte = b1_reg;
      3'd2:    cur_byte = b2_reg;
      3'd3:    cur_byte = b3_reg;
      3'd4:    cur_byte = b4_reg;
      default: cur_byte = b5_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      byte_reg    <= '0;
      shift_reg   <= '0;
      line_reg    <= 1'b1;
      b1_reg      <= '0;
      b2_reg      <= '0;
      b3_reg      <= '0;
      b4_reg      <= '0;
      b5_reg      <= '0;
      tx_reg      <= 1'b1;
      tx_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      // Outputs trail the FSM by one cycle; tx and tx_en share that delay so
      // the driver is always enabled whenever the line is driven low.
      tx_reg      <= line_reg;
      tx_en_reg   <= (state_reg != S_IDLE);
      busy_reg    <= (state_reg != S_IDLE);
      overrun_reg <= send && !accept;

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            b1_reg    <= cap_b1;
            b2_reg    <= current_max[7:0];
            b3_reg    <= cycle_count[15:8];
            b4_reg    <= cycle_count[7:0];
            b5_reg    <= cap_sum;
            byte_reg  <= '0;
            cnt_reg   <= LEAD_M1;
            line_reg  <= 1'b1;
            state_reg <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt_reg == '0) begin
            line_reg  <= 1'b0;
            cnt_reg   <= DIV_M1;
            state_reg <= S_START;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        S_START: begin
          if (cnt_reg == '0) begin
            line_reg  <= cur_byte[0];
            shift_reg <= {1'b0, cur_byte[7:1]};
            bit_reg   <= '0;
            cnt_reg   <= DIV_M1;
            state_reg <= S_DATA;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_reg == '0) begin
            cnt_reg <= DIV_M1;
            if (bit_reg == 3'd7) begin
              line_reg  <= 1'b1;
              state_reg <= S_STOP;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              line_reg  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_reg == '0) begin
            if (byte_reg < 3'd5) begin
              byte_reg  <= byte_reg + 3'd1;
              line_reg  <= 1'b0;
              cnt_reg   <= DIV_M1;
              state_reg <= S_START;
            end else begin
              cnt_reg   <= TAIL_M1;
              state_reg <= S_TAIL;
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        S_TAIL: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: begin
          line_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_en   = tx_en_reg;
  assign busy    = busy_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_rs485_telemetry_tx.sv
// Bench for rs485_telemetry_tx: vector table of payloads decoded off tx, plus
// overrun, input-stability, mid-frame reset and 160-cycle bit timing checks.
module tb_rs485_telemetry_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, send_a, send_b;
  logic [9:0]  current_max;
  logic [15:0] cycle_count;
  logic        fault, halt;
  logic        tx_a, tx_en_a, busy_a, overrun_a;
  logic        tx_b, tx_en_b, busy_b, overrun_b;

  rs485_telemetry_tx #(.CLK_DIV(16), .DE_LEAD(4), .DE_TAIL(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .send(send_a), .current_max(current_max),
    .cycle_count(cycle_count), .fault(fault), .halt(halt),
    .tx(tx_a), .tx_en(tx_en_a), .busy(busy_a), .overrun(overrun_a));

  rs485_telemetry_tx #(.CLK_DIV(160), .DE_LEAD(32), .DE_TAIL(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .send(send_b), .current_max(current_max),
    .cycle_count(cycle_count), .fault(fault), .halt(halt),
    .tx(tx_b), .tx_en(tx_en_b), .busy(busy_b), .overrun(overrun_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  cm;
    logic [15:0] cc;
    logic        f;
    logic        h;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs[5];

  // Monitors for dut_a busy window and overrun pulses
  int busy_rise_a, busy_fall_a, ovr_cnt;
  logic busy_prev_a = 1'b0;
  initial ovr_cnt = 0;
  always @(negedge clk) begin
    if (busy_a === 1'b1 && busy_prev_a === 1'b0) busy_rise_a = cyc;
    if (busy_a === 1'b0 && busy_prev_a === 1'b1) busy_fall_a = cyc;
    busy_prev_a = busy_a;
    if (overrun_a === 1'b1) ovr_cnt++;
  end

  // Monitor for dut_b tx transitions relative to the first start edge
  logic b_armed = 1'b0, b_started = 1'b0, b_prev = 1'b1, busy_prev_b = 1'b0;
  int b_t0, b_bad, b_edges, busy_rise_b, busy_fall_b;
  initial begin b_bad = 0; b_edges = 0; end
  always @(negedge clk) begin
    if (b_armed && tx_b !== b_prev) begin
      if (!b_started) begin
        b_started = 1'b1;
        b_t0 = cyc;
      end else if (((cyc - b_t0) % 160) != 0) begin
        b_bad++;
      end
      b_edges++;
    end
    b_prev = tx_b;
    if (busy_b === 1'b1 && busy_prev_b === 1'b0) busy_rise_b = cyc;
    if (busy_b === 1'b0 && busy_prev_b === 1'b1) busy_fall_b = cyc;
    busy_prev_b = busy_b;
  end

  function automatic int count_edges(input logic [47:0] fr);
    logic prev = 1'b1;
    logic bitv;
    int e = 0;
    for (int j = 0; j < 6; j++) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0) bitv = 1'b0;
        else if (b == 9) bitv = 1'b1;
        else bitv = fr[(5 - j) * 8 + b - 1];
        if (bitv != prev) e++;
        prev = bitv;
      end
    end
    return e;
  endfunction

  logic [47:0] rx_frame;
  int rx_t0;

  // Decode one frame from dut_a (CLK_DIV=16) sampling mid-bit from the first start edge
  task automatic decode_a(input string tag);
    int w = 0;
    int target;
    bit frame_bad = 0, en_bad = 0;
    rx_frame = '0;
    while (tx_a !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (tx_a !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s_start_timeout: got tx=%b expected start bit within 400 cycles", tag, tx_a);
      return;
    end
    rx_t0 = cyc;
    for (int k = 0; k < 60; k++) begin
      target = rx_t0 + k * 16 + 8;
      while (cyc < target) @(negedge clk);
      if (tx_en_a !== 1'b1) en_bad = 1;
      if (k % 10 == 0) begin
        if (tx_a !== 1'b0) frame_bad = 1;
      end else if (k % 10 == 9) begin
        if (tx_a !== 1'b1) frame_bad = 1;
      end else begin
        rx_frame[(5 - k / 10) * 8 + (k % 10 - 1)] = tx_a;
      end
    end
    check({tag, "_framing_err"}, 48'(frame_bad), 48'd0);
    check({tag, "_txen_drop"}, 48'(en_bad), 48'd0);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp);
    for (int j = 0; j < 6; j++)
      check($sformatf("%s_byte%0d", tag, j), 48'(rx_frame[(5 - j) * 8 +: 8]), 48'(exp[(5 - j) * 8 +: 8]));
  endtask

  task automatic wait_idle_a(input string tag);
    int w = 0;
    while (busy_a !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (busy_a !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout: got busy=%b expected 0 within 3000 cycles", tag, busy_a);
    end
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    current_max = v.cm;
    cycle_count = v.cc;
    fault = v.f;
    halt = v.h;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int n, o0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    send_a = 1'b0;
    send_b = 1'b0;
    current_max = '0;
    cycle_count = '0;
    fault = 1'b0;
    halt = 1'b0;

    vecs[0] = '{10'h280, 16'h0014, 1'b1, 1'b1, 48'hA5C280001456};
    vecs[1] = '{10'h3FF, 16'hFFFF, 1'b0, 1'b0, 48'hA503FFFFFF00};
    vecs[2] = '{10'h000, 16'h0000, 1'b0, 1'b0, 48'hA50000000000};
    vecs[3] = '{10'h155, 16'h1234, 1'b1, 1'b0, 48'hA581551234_1C};
    vecs[4] = '{10'h0AA, 16'hBEEF, 1'b0, 1'b1, 48'hA540AABEEF97};

    repeat (3) @(negedge clk);
    check("reset_tx", 48'(tx_a), 48'd1);
    check("reset_tx_en", 48'(tx_en_a), 48'd0);
    check("reset_busy", 48'(busy_a), 48'd0);
    check("reset_overrun", 48'(overrun_a), 48'd0);
    check("reset_b_outputs", 48'({tx_b, tx_en_b, busy_b, overrun_b}), 48'b1000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      apply_vec(vecs[i]);
      send_a = 1'b1;
      n = cyc + 1;
      @(negedge clk);
      send_a = 1'b0;
      check($sformatf("v%0d_txen_before", i), 48'(tx_en_a), 48'd0);
      @(negedge clk);
      check($sformatf("v%0d_txen_busy_rise", i), 48'({tx_en_a, busy_a}), 48'b11);
      decode_a($sformatf("v%0d", i));
      check($sformatf("v%0d_start_offset", i), 48'(rx_t0 - n), 48'd5);
      check_frame($sformatf("v%0d", i), vecs[i].exp);
      wait_idle_a($sformatf("v%0d", i));
      check($sformatf("v%0d_busy_len", i), 48'(busy_fall_a - busy_rise_a), 48'd968);
      $display("vec %0d: frame %012h busy %0d cycles", i, rx_frame, busy_fall_a - busy_rise_a);
    end

    // Second send 100 cycles into a frame is dropped with a single overrun pulse
    apply_vec(vecs[0]);
    o0 = ovr_cnt;
    send_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_a = 1'b0;
    fork
      decode_a("ovr_mid");
      begin
        wait_cyc(n + 99);
        apply_vec(vecs[1]);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        check("ovr_mid_pulse", 48'(overrun_a), 48'd1);
        @(negedge clk);
        check("ovr_mid_pulse_end", 48'(overrun_a), 48'd0);
      end
    join
    check_frame("ovr_mid", vecs[0].exp);
    wait_idle_a("ovr_mid");
    check("ovr_mid_count", 48'(ovr_cnt - o0), 48'd1);
    check("ovr_mid_busy_len", 48'(busy_fall_a - busy_rise_a), 48'd968);
    $display("overrun mid-frame: frame %012h pulses %0d", rx_frame, ovr_cnt - o0);

    // Send on the edge where TAIL returns to IDLE is dropped
    apply_vec(vecs[2]);
    o0 = ovr_cnt;
    send_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_a = 1'b0;
    decode_a("ovr_tail");
    check_frame("ovr_tail", vecs[2].exp);
    wait_cyc(n + 967);
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    check("ovr_tail_pulse", 48'(overrun_a), 48'd1);
    repeat (30) @(negedge clk);
    check("ovr_tail_dropped", 48'({busy_a, tx_en_a}), 48'd0);
    check("ovr_tail_count", 48'(ovr_cnt - o0), 48'd1);
    $display("overrun at tail end: pulses %0d busy %b", ovr_cnt - o0, busy_a);

    // Inputs scrambled every cycle after the send edge
    apply_vec(vecs[3]);
    send_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_a = 1'b0;
    fork
      decode_a("stable");
      begin
        repeat (960) begin
          current_max = 10'($urandom);
          cycle_count = 16'($urandom);
          fault = 1'($urandom);
          halt = 1'($urandom);
          @(negedge clk);
        end
      end
    join
    check_frame("stable", vecs[3].exp);
    wait_idle_a("stable");
    $display("input stability: frame %012h", rx_frame);

    // Asynchronous reset during DATA of byte 3
    apply_vec(vecs[4]);
    send_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_a = 1'b0;
    wait_cyc(n + 5 + 30 * 16 + 16 + 40);
    check("rst_pre_txen", 48'({tx_en_a, busy_a}), 48'b11);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_outputs", 48'({tx_a, tx_en_a, busy_a, overrun_a}), 48'b1000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_vec(vecs[0]);
    send_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_a = 1'b0;
    decode_a("rst_after");
    check("rst_after_start_offset", 48'(rx_t0 - n), 48'd5);
    check_frame("rst_after", vecs[0].exp);
    wait_idle_a("rst_after");
    check("rst_after_busy_len", 48'(busy_fall_a - busy_rise_a), 48'd968);
    $display("mid-frame reset: new frame %012h", rx_frame);

    // Bit timing on the 160-cycle instance
    apply_vec(vecs[3]);
    b_armed = 1'b1;
    @(negedge clk);
    send_b = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    send_b = 1'b0;
    begin
      int w = 0;
      while ((busy_b !== 1'b0 || w < 2) && w < 12000) begin
        @(negedge clk);
        w++;
      end
      if (busy_b !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL bit_timing_idle_timeout: got busy=%b expected 0", busy_b);
      end
    end
    @(negedge clk);
    check("bit_timing_start_offset", 48'(b_t0 - n), 48'd33);
    check("bit_timing_misaligned", 48'(b_bad), 48'd0);
    check("bit_timing_edges", 48'(b_edges), 48'(count_edges(vecs[3].exp)));
    check("bit_timing_busy_len", 48'(busy_fall_b - busy_rise_b), 48'd9664);
    $display("bit timing: edges %0d misaligned %0d busy %0d", b_edges, b_bad, busy_fall_b - busy_rise_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
